// File: rtl/rps_pkg.sv
// Shared types and constants for the rock/paper/scissors stream classifier.
// Pixel channels are packed ch2 (hue) in the top byte down to ch0 in the bottom byte.
package rps_pkg;

  typedef logic [2:0][7:0] pixel_t;

  typedef enum logic [2:0] {
    ROCK     = 3'd0,
    PAPER    = 3'd1,
    SCISSORS = 3'd2,
    INVALID  = 3'd7
  } rps_result_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DECIDE = 2'd2,
    HOLD   = 2'd3
  } ctrl_state_e;

  localparam pixel_t LOWER_GREEN = {8'd36, 8'd25, 8'd25};
  localparam pixel_t UPPER_GREEN = {8'd86, 8'd255, 8'd255};

  // Framing errors dominate; an exact transition match beats the green-area test.
  function automatic rps_result_e classify(
    input logic        err,
    input logic [31:0] trans,
    input logic [31:0] sum,
    input logic [31:0] paper_thresh,
    input logic [31:0] scissors_trans
  );
    rps_result_e res;
    if (err) begin
      res = INVALID;
    end else if (trans == scissors_trans) begin
      res = SCISSORS;
    end else if (sum > paper_thresh) begin
      res = PAPER;
    end else begin
      res = ROCK;
    end
    return res;
  endfunction

endpackage

// File: rtl/green_pixel_match.sv
// Inclusive per-channel window test; a pixel matches only when every channel is in range.
module green_pixel_match
  import rps_pkg::*;
(
  input  pixel_t pix_i,
  input  pixel_t lower_i,
  input  pixel_t upper_i,
  output logic   match_o
);

  always_comb begin
    match_o = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if ((pix_i[c] < lower_i[c]) || (pix_i[c] > upper_i[c])) begin
        match_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rps_stream_classifier_ctrl.sv
// Frame controller: accumulates green statistics over a streamed frame and hands
// one classification per frame to the consumer.
module rps_stream_classifier_ctrl
  import rps_pkg::*;
#(
  parameter int unsigned HEIGHT         = 100,
  parameter int unsigned LENGTH         = 100,
  parameter int unsigned LEFT_COLS      = 50,
  parameter int unsigned STRIP_COL      = 50,
  parameter int unsigned PAPER_THRESH   = 1200,
  parameter int unsigned SCISSORS_TRANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [23:0] pix_data,
  input  logic        pix_last,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [2:0]  result,
  output logic        res_err,
  output logic        busy,
  output logic [31:0] sum_left,
  output logic [31:0] transitions,
  output ctrl_state_e dbg_state_o
);

  // Handshakes: a pixel beat transfers on a cycle where pix_valid & pix_ready are
  // both high at the rising edge; likewise a result transfers on res_valid & res_ready.
  // Neither ready nor valid from this block depends combinationally on the partner.

  ctrl_state_e state_q, state_d;
  logic [31:0] row_q, row_d;
  logic [31:0] col_q, col_d;
  logic [31:0] sum_q, sum_d;
  logic [31:0] trans_q, trans_d;
  logic        prev_q, prev_d;
  logic        err_q, err_d;
  rps_result_e result_q, result_d;

  logic green;
  logic final_idx;

  green_pixel_match u_green (
    .pix_i   (pixel_t'(pix_data)),
    .lower_i (LOWER_GREEN),
    .upper_i (UPPER_GREEN),
    .match_o (green)
  );

  assign final_idx = (row_q == HEIGHT - 1) && (col_q == LENGTH - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      sum_q    <= '0;
      trans_q  <= '0;
      prev_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= ROCK;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      sum_q    <= sum_d;
      trans_q  <= trans_d;
      prev_q   <= prev_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    sum_d     = sum_q;
    trans_d   = trans_q;
    prev_d    = prev_q;
    err_d     = err_q;
    result_d  = result_q;
    pix_ready = 1'b0;
    res_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          row_d   = '0;
          col_d   = '0;
          sum_d   = '0;
          trans_d = '0;
          prev_d  = 1'b0;
          err_d   = 1'b0;
        end
      end

      STREAM: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          if (green && (col_q < LEFT_COLS)) begin
            sum_d = sum_q + 32'd1;
          end
          // Row 0 only seeds the strip history; later rows count level changes.
          if (col_q == STRIP_COL) begin
            if ((row_q != '0) && (green != prev_q)) begin
              trans_d = trans_q + 32'd1;
            end
            prev_d = green;
          end
          if (pix_last || final_idx) begin
            state_d = DECIDE;
            err_d   = pix_last ^ final_idx;
          end else if (col_q == LENGTH - 1) begin
            col_d = '0;
            row_d = row_q + 32'd1;
          end else begin
            col_d = col_q + 32'd1;
          end
        end
      end

      DECIDE: begin
        result_d = classify(err_q, trans_q, sum_q, 32'(PAPER_THRESH), 32'(SCISSORS_TRANS));
        state_d  = HOLD;
      end

      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign result      = result_q;
  assign res_err     = err_q;
  assign busy        = (state_q != IDLE);
  assign sum_left    = sum_q;
  assign transitions = trans_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rps_stream_classifier_ctrl.sv
// Directed bench for the rock/paper/scissors frame controller.
module tb_rps_stream_classifier_ctrl;
  import rps_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, pix_valid, pix_ready, pix_last;
  logic        res_valid, res_ready, res_err, busy;
  logic [23:0] pix_data;
  logic [2:0]  result;
  logic [31:0] sum_left, transitions;
  ctrl_state_e dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_q[$];

  rps_stream_classifier_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_last    (pix_last),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .res_err     (res_err),
    .busy        (busy),
    .sum_left    (sum_left),
    .transitions (transitions),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0 all zero, 1 left half green, 2 left green plus strip bands, 3 hue boundaries
  function automatic logic [23:0] pix_for(input int mode, input int row, input int col);
    logic [23:0] p;
    p = '0;
    if ((mode == 1 || mode == 2) && col < 50) p = 24'h3C6464;
    if (mode == 2 && col == 50 && ((row >= 20 && row < 40) || (row >= 60 && row < 80)))
      p = 24'h3C6464;
    if (mode == 3 && col < 50) begin
      case (col % 5)
        0:       p = {8'd36, 8'd25, 8'd25};
        1:       p = {8'd86, 8'd255, 8'd255};
        2:       p = {8'd35, 8'd100, 8'd100};
        3:       p = {8'd87, 8'd100, 8'd100};
        default: p = {8'd60, 8'd24, 8'd100};
      endcase
    end
    return p;
  endfunction

  task automatic start_frame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic drive_frame(input int mode, input int last_idx, input int n_beats);
    int stalls;
    stalls = 0;
    for (int i = 0; i < n_beats; i++) begin
      pix_valid = 1'b1;
      pix_data  = pix_for(mode, i / 100, i % 100);
      pix_last  = (i == last_idx);
      if (!pix_ready) stalls++;
      @(posedge clk);
      @(negedge clk);
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    pix_data  = '0;
    chk("ready_during_stream", stalls, 0);
  endtask

  task automatic check_result(input string name, input int exp_sum, input int exp_trans,
                              input logic exp_err);
    int lat;
    lat = 1;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, 2);
    if (exp_q.size() > 0) chk({name, "_result"}, result, exp_q.pop_front());
    else chk({name, "_exp_queue"}, 0, 1);
    chk({name, "_sum_left"}, sum_left, exp_sum);
    chk({name, "_transitions"}, transitions, exp_trans);
    chk({name, "_res_err"}, res_err, exp_err);
    chk({name, "_busy_hold"}, busy, 1);
    chk({name, "_ready_hold"}, pix_ready, 0);
  endtask

  task automatic handshake(input string name);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({name, "_valid_drop"}, res_valid, 0);
    chk({name, "_busy_drop"}, busy, 0);
    chk({name, "_state_idle"}, dbg_state, IDLE);
  endtask

  initial begin
    logic [2:0]  held_res;
    logic [31:0] held_sum;
    int          spurious;

    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_last = 1'b0;
    pix_data = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_result", result, 0);
    chk("rst_sum_left", sum_left, 0);
    chk("rst_transitions", transitions, 0);
    chk("rst_res_err", res_err, 0);

    exp_q.push_back(ROCK);
    start_frame();
    drive_frame(0, 9999, 10000);
    check_result("zero", 0, 0, 1'b0);
    handshake("zero");

    exp_q.push_back(PAPER);
    start_frame();
    drive_frame(1, 9999, 10000);
    check_result("paper", 5000, 0, 1'b0);
    handshake("paper");

    exp_q.push_back(SCISSORS);
    start_frame();
    drive_frame(2, 9999, 10000);
    check_result("scissors", 5000, 4, 1'b0);
    handshake("scissors");

    // reset in the middle of a frame
    start_frame();
    for (int i = 0; i < 300; i++) begin
      pix_valid = 1'b1;
      pix_data  = pix_for(1, i / 100, i % 100);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_pix_ready", pix_ready, 0);
    chk("midrst_result", result, 0);
    chk("midrst_sum_left", sum_left, 0);
    chk("midrst_transitions", transitions, 0);
    chk("midrst_res_err", res_err, 0);
    rst = 1'b0;
    pix_valid = 1'b0;
    spurious = 0;
    repeat (5) begin
      @(negedge clk);
      if (res_valid || busy) spurious++;
    end
    chk("midrst_quiet", spurious, 0);

    // early pix_last on beat 500
    exp_q.push_back(INVALID);
    start_frame();
    drive_frame(1, 500, 501);
    check_result("early_last", 251, 0, 1'b1);
    held_res = result;
    held_sum = sum_left;
    for (int i = 0; i < 10; i++) begin
      start = ~start;
      @(negedge clk);
      chk("stall_result", result, 7);
      chk("stall_stable", {result, sum_left[28:0]}, {held_res, held_sum[28:0]});
      chk("stall_busy", busy, 1);
      chk("stall_valid", res_valid, 1);
    end
    start = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    res_ready = 1'b0;
    chk("hs_start_busy", busy, 0);
    chk("hs_start_valid", res_valid, 0);
    @(negedge clk);
    chk("hs_start_ignored", busy, 0);

    exp_q.push_back(PAPER);
    start_frame();
    drive_frame(3, 9999, 10000);
    check_result("boundary", 2000, 0, 1'b0);
    handshake("boundary");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
